// File: rtl/sqrt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sqrt_pkg
//  Purpose  : Shared constants for the square-root controller and datapath:
//             FSM state encoding and default widths/limits.
//  Revision : 1.0  initial release
// ============================================================================
package sqrt_pkg;

    localparam int ROOT_W_DEF   = 8;
    localparam int ITER_W_DEF   = 9;
    localparam int MAX_ITER_DEF = 256;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_BOOT     = 3'd1,
        S_CMP      = 3'd2,
        S_INC_ROOT = 3'd3,
        S_ADD_SQ   = 3'd4,
        S_DONE     = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sqrt_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : sqrt_control_unit_if
//  Purpose  : Start/result handshake between a requester and the square-root
//             controller.
//  Signals  : start_i, ack_i            requester -> controller
//             ready_o, busy_o, valid_o,
//             result_o, overflow_o      controller -> requester
//  Modports : master (requester side), slave (controller side)
//  Revision : 1.0  initial release
// ============================================================================
interface sqrt_control_unit_if #(
    parameter int ROOT_W = 8
);
    logic              start_i;
    logic              ack_i;
    logic              ready_o;
    logic              busy_o;
    logic              valid_o;
    logic [ROOT_W-1:0] result_o;
    logic              overflow_o;

    modport master (
        output start_i, ack_i,
        input  ready_o, busy_o, valid_o, result_o, overflow_o
    );

    modport slave (
        input  start_i, ack_i,
        output ready_o, busy_o, valid_o, result_o, overflow_o
    );
endinterface
`default_nettype wire

// File: rtl/sqrt_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : sqrt_control_unit
//  Purpose  : FSM controller for the iterative square-root datapath. Drives
//             boot / square write / root write / adder mux select, consumes
//             the datapath N flag and root value, captures the final root in
//             a result register held until acknowledged, and stops runaway
//             loops after MAX_ITER compare cycles.
//  Ports    : clk, rst_n              clock, async active-low reset
//             hs (slave)              start/ready/busy/result/valid/ack/overflow
//             boot_o, wr_square_o,
//             wr_root_o, muxes_o      datapath control
//             N_i, root_i             datapath status / root value
//             iter_o                  current iteration count (debug)
//  Revision : 1.0  initial release
// ============================================================================
module sqrt_control_unit
    import sqrt_pkg::*;
#(
    parameter int ROOT_W   = ROOT_W_DEF,
    parameter int MAX_ITER = MAX_ITER_DEF,
    parameter int ITER_W   = ITER_W_DEF
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    sqrt_control_unit_if.slave     hs,
    output logic                   boot_o,
    output logic                   wr_square_o,
    output logic                   wr_root_o,
    output logic                   muxes_o,
    input  wire logic              N_i,
    input  wire logic [ROOT_W-1:0] root_i,
    output logic [ITER_W-1:0]      iter_o
);

    localparam logic [ITER_W-1:0] c_ITER_LAST = ITER_W'(MAX_ITER - 1);

    state_t              r_state;
    logic [ITER_W-1:0]   r_iter;
    logic                r_ovf;
    logic                r_valid;
    logic [ROOT_W-1:0]   r_result;

    // ------------------------------------------------------------------------
    // State, iteration counter and result register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_iter   <= '0;
            r_ovf    <= 1'b0;
            r_valid  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (hs.start_i) begin
                        r_state <= S_BOOT;
                        r_iter  <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                S_BOOT: begin
                    r_state <= S_CMP;
                end
                S_CMP: begin
                    // N has priority: a natural finish on the last permitted
                    // compare is not an overflow.
                    if (N_i) begin
                        r_state  <= S_DONE;
                        r_result <= root_i;
                        r_valid  <= 1'b1;
                    end else if (r_iter == c_ITER_LAST) begin
                        r_state  <= S_DONE;
                        r_result <= root_i;
                        r_valid  <= 1'b1;
                        r_ovf    <= 1'b1;
                    end else begin
                        r_state <= S_INC_ROOT;
                        r_iter  <= r_iter + 1'b1;
                    end
                end
                S_INC_ROOT: begin
                    r_state <= S_ADD_SQ;
                end
                S_ADD_SQ: begin
                    r_state <= S_CMP;
                end
                S_DONE: begin
                    // A start seen together with ack is dropped: we only
                    // return to IDLE here.
                    if (hs.ack_i) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Moore decode of the registered state
    // ------------------------------------------------------------------------
    always_comb begin
        boot_o      = 1'b0;
        wr_square_o = 1'b0;
        wr_root_o   = 1'b0;
        muxes_o     = 1'b0;
        hs.ready_o  = 1'b0;
        hs.busy_o   = 1'b0;
        case (r_state)
            S_IDLE: begin
                hs.ready_o = 1'b1;
            end
            S_BOOT: begin
                boot_o      = 1'b1;
                wr_square_o = 1'b1;
                wr_root_o   = 1'b1;
                hs.busy_o   = 1'b1;
            end
            S_CMP: begin
                muxes_o   = 1'b1;
                hs.busy_o = 1'b1;
            end
            S_INC_ROOT: begin
                wr_root_o = 1'b1;
                hs.busy_o = 1'b1;
            end
            S_ADD_SQ: begin
                wr_square_o = 1'b1;
                hs.busy_o   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign hs.valid_o    = r_valid;
    assign hs.result_o   = r_result;
    assign hs.overflow_o = r_ovf;
    assign iter_o        = r_iter;

endmodule
`default_nettype wire

// File: tb/tb_sqrt_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sqrt_control_unit
//  Purpose  : Self-checking bench for sqrt_control_unit. A transaction-level
//             model derives, from the number of N=0 compares requested, the
//             cycle-by-cycle control pattern, latency, result and overflow.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sqrt_control_unit;

    localparam int ROOT_W   = 8;
    localparam int MAX_ITER = 4;
    localparam int ITER_W   = 3;

    // Phase kinds used by the model's expectation table
    localparam int K_IDLE = 0;
    localparam int K_BOOT = 1;
    localparam int K_CMP  = 2;
    localparam int K_INC  = 3;
    localparam int K_ADD  = 4;
    localparam int K_DONE = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              boot_o, wr_square_o, wr_root_o, muxes_o;
    logic              N_i;
    logic [ROOT_W-1:0] root_i;
    logic [ITER_W-1:0] iter_o;

    int n_checks = 0;
    int n_errors = 0;

    sqrt_control_unit_if #(.ROOT_W(ROOT_W)) ifc ();

    sqrt_control_unit #(
        .ROOT_W   (ROOT_W),
        .MAX_ITER (MAX_ITER),
        .ITER_W   (ITER_W)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hs          (ifc),
        .boot_o      (boot_o),
        .wr_square_o (wr_square_o),
        .wr_root_o   (wr_root_o),
        .muxes_o     (muxes_o),
        .N_i         (N_i),
        .root_i      (root_i),
        .iter_o      (iter_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {ready, busy, boot, wr_square, wr_root, muxes, valid}
    function automatic logic [31:0] ctl_vec();
        return 32'({ifc.ready_o, ifc.busy_o, boot_o, wr_square_o,
                    wr_root_o, muxes_o, ifc.valid_o});
    endfunction

    function automatic logic [31:0] exp_vec(input int kind);
        case (kind)
            K_BOOT:  return 32'b0111100;
            K_CMP:   return 32'b0100010;
            K_INC:   return 32'b0100100;
            K_ADD:   return 32'b0101000;
            K_DONE:  return 32'b0000001;
            default: return 32'b1000000;
        endcase
    endfunction

    function automatic logic [ROOT_W-1:0] pick_root(input int root_fix);
        logic [31:0] v;
        v = (root_fix >= 0) ? 32'(root_fix) : $urandom;
        return v[ROOT_W-1:0];
    endfunction

    // One request. k = number of compares that see N=0 before the first N=1
    // (k >= MAX_ITER means N never rises in time -> overflow).
    task automatic run_txn(input int k, input int root_fix, input bit do_rst, input int hold_req);
        int                L;
        int                tdone;
        int                hold;
        int                kind;
        bit                ovf;
        logic [ROOT_W-1:0] exp_res;

        L       = (k >= MAX_ITER) ? MAX_ITER - 1 : k;
        ovf     = (k >= MAX_ITER);
        tdone   = 3 + 3 * L;
        exp_res = '0;

        check("ready_idle", 32'(ifc.ready_o), 32'd1);
        ifc.start_i = 1'b1;
        ifc.ack_i   = 1'($urandom);
        N_i         = 1'($urandom);
        root_i      = pick_root(root_fix);
        @(posedge clk); #1;

        for (int t = 1; t < tdone; t++) begin
            if (t == 1)               kind = K_BOOT;
            else if ((t - 2) % 3 == 0) kind = K_CMP;
            else if ((t - 2) % 3 == 1) kind = K_INC;
            else                       kind = K_ADD;

            check("ctl_busy", ctl_vec(), exp_vec(kind));
            check("iter_busy", 32'(iter_o),
                  32'((t < 2) ? 0 : ((t - 2) / 3 + (((t - 2) % 3 != 0) ? 1 : 0))));
            if (t == 1) check("ovf_clear", 32'(ifc.overflow_o), 32'd0);

            // start/ack while busy must be ignored; N only matters in compares
            ifc.start_i = 1'($urandom);
            ifc.ack_i   = 1'($urandom);
            N_i         = 1'($urandom);
            root_i      = pick_root(root_fix);
            if (kind == K_CMP) N_i = (((t - 2) / 3) == k);
            if (t == tdone - 1) exp_res = root_i;

            if (do_rst && kind == K_ADD) begin
                ifc.start_i = 1'b1;
                #3 rst_n = 1'b0;
                #1;
                check("rst_async_ctl", ctl_vec(), exp_vec(K_IDLE));
                check("rst_async_res", 32'(ifc.result_o), 32'd0);
                check("rst_async_ovf", 32'(ifc.overflow_o), 32'd0);
                check("rst_async_iter", 32'(iter_o), 32'd0);
                @(posedge clk); #1;
                check("rst_hold_ctl", ctl_vec(), exp_vec(K_IDLE));
                #2 rst_n = 1'b1;
                ifc.start_i = 1'b0;
                ifc.ack_i   = 1'b0;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end

        hold = (hold_req >= 0) ? hold_req : $urandom_range(0, 3);
        for (int h = 0; h <= hold; h++) begin
            check("ctl_done", ctl_vec(), exp_vec(K_DONE));
            check("result", 32'(ifc.result_o), 32'(exp_res));
            check("overflow", 32'(ifc.overflow_o), 32'(ovf));
            check("iter_done", 32'(iter_o), 32'(L));
            ifc.ack_i   = (h == hold);
            ifc.start_i = 1'($urandom);
            N_i         = 1'($urandom);
            root_i      = pick_root(-1);
            @(posedge clk); #1;
        end
        check("ctl_after_ack", ctl_vec(), exp_vec(K_IDLE));
        ifc.start_i = 1'b0;
        ifc.ack_i   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifc.start_i = 1'b1;
        ifc.ack_i   = 1'b0;
        N_i         = 1'b0;
        root_i      = '0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", ctl_vec(), exp_vec(K_IDLE));
        check("reset_result", 32'(ifc.result_o), 32'd0);
        check("reset_ovf", 32'(ifc.overflow_o), 32'd0);
        check("reset_iter", 32'(iter_o), 32'd0);
        ifc.start_i = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", ctl_vec(), exp_vec(K_IDLE));

        run_txn(0, 0, 1'b0, 2);     // immediate exit, root 0
        run_txn(3, 3, 1'b0, 5);     // three iterations, long hold in DONE
        run_txn(10, -1, 1'b0, 1);   // N stuck low -> overflow
        run_txn(1, -1, 1'b0, 0);    // overflow cleared by new start
        run_txn(3, -1, 1'b0, 0);    // N rises on last permitted compare
        run_txn(5, -1, 1'b1, 0);    // async reset mid-loop
        run_txn(2, -1, 1'b0, -1);   // full run after reset

        for (int i = 0; i < 40; i++) begin
            run_txn($urandom_range(0, 6), -1, 1'b0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sqrt_control_unit.md
Name: sqrt_control_unit

Overview:
- FSM controller that drives the control inputs of the square-root datapath (boot, square write, root write, adder mux select) and consumes its N flag and root output.
- Sits directly upstream of the datapath and owns the start/result handshake toward the requesting logic.
- Captures the final root into a result register held until acknowledged.
- Guards against runaway loops with an iteration limit.

Parameters:
- ROOT_W, 8, width of root_i and result_o.
- MAX_ITER, 256, maximum loop iterations (CMP cycles with N_i=0) before forced termination.
- ITER_W, 9, width of the iteration counter; must satisfy 2^ITER_W > MAX_ITER.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  request a new computation; accepted only when ready_o=1.
- ready_o  out  1  high in IDLE only.
- busy_o  out  1  high in BOOT, CMP, INC_ROOT, ADD_SQ.
- boot_o  out  1  to datapath boot_i.
- wr_square_o  out  1  to datapath wr_square_i.
- wr_root_o  out  1  to datapath wr_root_i.
- muxes_o  out  1  to datapath muxes_i (1 = compare valor−square, 0 = square update).
- N_i  in  1  datapath N_o (1 = square exceeds valor).
- root_i  in  ROOT_W  datapath root_o.
- result_o  out  ROOT_W  captured root, registered.
- valid_o  out  1  result_o valid; held until ack_i.
- ack_i  in  1  consumer accepts result.
- overflow_o  out  1  result terminated by the MAX_ITER guard; valid only with valid_o.
- iter_o  out  ITER_W  current iteration count (debug).

Behaviour:
- States: IDLE, BOOT, CMP, INC_ROOT, ADD_SQ, DONE. Binary encoded, single registered state.
- Moore control outputs, decoded combinationally from state:
  - IDLE: all control outputs 0.
  - BOOT: boot_o=1, wr_square_o=1, wr_root_o=1, muxes_o=0.
  - CMP: muxes_o=1, no writes.
  - INC_ROOT: wr_root_o=1, muxes_o=0.
  - ADD_SQ: wr_square_o=1, muxes_o=0.
  - DONE: all control outputs 0.
- Transitions:
  - IDLE→BOOT on start_i.
  - BOOT→CMP.
  - CMP→DONE if N_i=1.
  - CMP→DONE if N_i=0 and iter==MAX_ITER−1; overflow flag set.
  - CMP→INC_ROOT otherwise; iter+1.
  - INC_ROOT→ADD_SQ.
  - ADD_SQ→CMP.
  - DONE→IDLE when ack_i=1.
- N_i is sampled only in CMP; ignored in all other states.
- On every transition into DONE, result_o<=root_i and valid_o<=1 in the same edge; result_o is stable throughout DONE.
- iter cleared on IDLE→BOOT; overflow flag cleared on IDLE→BOOT.
- Latency: for k loop iterations (k CMP cycles with N_i=0), valid_o rises 3+3k cycles after the cycle in which start_i is accepted.
- start_i while not in IDLE: ignored, no queuing.
- start_i and ack_i both high in DONE: return to IDLE only; the start is not accepted that cycle.
- ack_i outside DONE: ignored.
- Reset (async assert, any state including mid-loop) forces:
  - state=IDLE, result_o=0, valid_o=0, overflow_o=0, iter_o=0;
  - all control outputs 0, ready_o=1, busy_o=0.
- Reset deassertion: first active edge evaluates IDLE normally.

Decomposition:
- Shared package sqrt_pkg holds the state encodings (IDLE..DONE localparams) and default widths (ROOT_W, ITER_W), so datapath and top level use the same constants.
- No sub-module: FSM, counter and result register live in one module. The existing datapath is instantiated alongside it at the sqrt top level, not inside this block.

Test Plan:
- Reset: hold rst_n=0 with start_i=1 → ready_o=1, busy_o=0, valid_o=0, result_o=0, all control outputs 0.
- Immediate exit: start_i pulse, stub drives N_i=1 in first CMP, root_i=8'h00 → sequence BOOT, CMP, DONE; valid_o rises 3 cycles after acceptance; result_o=0, overflow_o=0.
- Three iterations: stub N_i=0 for 3 CMPs then 1, root_i=8'd3 → control sequence BOOT,(CMP,INC_ROOT,ADD_SQ)×3,CMP; exact boot/wr_square/wr_root/muxes values checked per cycle; valid_o at cycle 12; result_o=3; iter_o=3.
- Handshake: hold ack_i=0 for 5 cycles in DONE, toggle root_i → result_o and valid_o stable; ack_i=1 → IDLE next edge. start_i during busy is ignored.
- Overflow: MAX_ITER=4, N_i stuck 0 → DONE after 4th CMP, overflow_o=1, valid_o=1; next start clears overflow_o.
- Mid-operation reset: assert rst_n=0 asynchronously during ADD_SQ → outputs drop to reset values before the next clk edge; new start after release runs a full sequence from BOOT.
